dnn_input_loader: RTL
=====================

# dnn_input_loader

Upstream feeder for `dnn_top`. It accepts a byte-serial pixel stream over a valid/ready handshake, converts each pixel to a 16-bit signed sample and fills the `INPUT_SIZE`-entry `input_vector` buffer. When a frame is complete it holds `start` to `dnn_top` until `done` returns, then publishes the predicted digit. It sits between the host/UART byte path and the inference core, and replaces the memory-file image load used in simulation.

## Interface
- `INPUT_SIZE`, 784, pixels per frame; one buffer entry each.
- `CNT_W`, `$clog2(INPUT_SIZE)`, width of the pixel counter.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `s_valid`  in  1  pixel byte valid.
- `s_data`  in  8  unsigned pixel, 0..255.
- `s_last`  in  1  marks the final pixel of a frame; qualified by `s_valid`.
- `s_ready`  out  1  loader can accept a pixel.
- `input_vector`  out  16×`INPUT_SIZE`  signed samples to `dnn_top`.
- `start`  out  1  run request to `dnn_top`.
- `dnn_done`  in  1  `done` from `dnn_top`.
- `dnn_digit`  in  4  `final_digit` from `dnn_top`.
- `result_valid`  out  1  one-cycle pulse when a new digit is available.
- `result_digit`  out  4  last predicted digit; held until the next result.
- `frame_err`  out  1  one-cycle pulse when a frame is dropped.

## Operation
- FSM states: LOAD, RUN, REPORT. Reset enters LOAD.
- **LOAD**
  - `s_ready`=1, driven combinationally from state.
  - Each accepted beat (`s_valid && s_ready`) writes the converted sample to `input_vector[cnt]`, then `cnt` increments.
  - Accepted beat with `s_last`=1 and `cnt==INPUT_SIZE-1`: frame good; go to RUN; `cnt` clears to 0.
  - Accepted beat with `s_last`=1 and `cnt<INPUT_SIZE-1`: `frame_err` pulses; `cnt` clears to 0; stay in LOAD. Entries already written are left stale and are overwritten by the next frame.
  - Accepted beat with `cnt==INPUT_SIZE-1` and `s_last`=0: treated the same way (`frame_err`, `cnt` cleared, stay in LOAD). The pixel is written but the frame is discarded.
- **RUN**
  - `s_ready`=0; `start`=1 (registered). `input_vector` does not change.
  - `dnn_done` sampled high: `result_digit` captures `dnn_digit`; go to REPORT.
- **REPORT** (one cycle)
  - `result_valid`=1; `start`=0; next state is LOAD.
- `dnn_done` high while in LOAD or REPORT is ignored.
- `cnt` never exceeds `INPUT_SIZE-1`; there is no wrap-around path.

## Timing
- Reset values:
  - `s_ready`=1 (state is LOAD).
  - `start`=0, `result_valid`=0, `result_digit`=0, `frame_err`=0.
  - All `input_vector` entries = 0; `cnt`=0.
- Throughput in LOAD: one pixel per cycle.
- Last beat accepted at edge N:
  - `start`=1 and `s_ready`=0 from edge N+1.
- `dnn_done` high sampled at edge M:
  - `start`=0 and `result_valid`=1 from edge M+1, for one cycle.
  - `s_ready`=1 from edge M+2.
- `frame_err` is high in the cycle after the offending beat, for exactly one cycle.
- Reset asserted mid-frame or in RUN forces the reset values immediately. No partial result is reported.

## Configuration
- `DNN_LOADER_NORMALIZE_EN` defined: sample = `{1'b0, s_data, 7'b0}`, i.e. pixel/256 in Q1.15. 255 maps to 0x7F80.
- Not defined: sample = `{8'b0, s_data}`, raw zero-extended integer. 255 maps to 0x00FF.
- Control behaviour and timing are identical in both builds.

## Test plan
- **Reset:** hold `rst_n`=0 → `s_ready`=1, `start`=0, `result_digit`=0, `input_vector[0]`=0 and `input_vector[783]`=0.
- **Good frame, macro off:** stream 784 bytes, byte k = k mod 256, `s_last` on byte 783 → `input_vector[300]`=0x002C; `start` rises the cycle after the last beat; `s_ready`=0.
- **Result handoff:** during RUN, drive `dnn_done`=1 with `dnn_digit`=7 → next cycle `start`=0, `result_valid`=1 for one cycle, `result_digit`=7 and held; `s_ready`=1 the following cycle.
- **Short frame:** `s_last` on beat 99 → `frame_err` pulses once; `start` stays 0; a following good frame completes normally.
- **Missing `s_last`:** 784 beats with no `s_last` → `frame_err` on beat 784; no `start`; `cnt` back at 0.
- **Macro on, backpressure and reset:** `s_data`=255 → entry = 0x7F80; with `s_valid` toggled every other cycle, all 784 beats are still captured; asserting `rst_n`=0 while in RUN → `start`=0 immediately and no `result_valid` pulse.

Source files
------------

// File: rtl/dnn_input_loader.sv
// ---------------------------------------------------------------------------
// dnn_input_loader
//
// Purpose:
//   Front end for the inference core. Collects a byte-serial pixel stream
//   over a valid/ready handshake, converts each pixel to a 16-bit signed
//   sample and fills the INPUT_SIZE-entry input_vector buffer. Once a whole
//   frame has arrived it holds start until the core answers with done, then
//   publishes the predicted digit for one cycle.
//
// Build option:
//   DNN_LOADER_NORMALIZE_EN
//     defined     : sample = {1'b0, pixel, 7'b0}  (pixel/256 in Q1.15)
//     not defined : sample = {8'b0, pixel}        (raw zero-extended value)
//   Control behaviour and timing are the same in both builds.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   s_valid       in   pixel byte valid
//   s_data        in   unsigned pixel, 0..255
//   s_last        in   final pixel of a frame (qualified by s_valid)
//   s_ready       out  loader can accept a pixel (high only in LOAD)
//   input_vector  out  INPUT_SIZE signed 16-bit samples to the core
//   start         out  run request to the core (registered)
//   dnn_done      in   done from the core
//   dnn_digit     in   final_digit from the core
//   result_valid  out  one-cycle pulse when a new digit is available
//   result_digit  out  last predicted digit, held until the next result
//   frame_err     out  one-cycle pulse when a frame is dropped
//
// States:
//   LOAD   | accepting pixels into input_vector
//   RUN    | frame complete, start held until dnn_done
//   REPORT | one cycle, result_valid pulses, then back to LOAD
// ---------------------------------------------------------------------------
module dnn_input_loader #(
  parameter int INPUT_SIZE = 784,
  parameter int CNT_W      = $clog2(INPUT_SIZE)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  input  logic [7:0]          s_data,
  input  logic                s_last,
  output logic                s_ready,
  output logic signed [15:0]  input_vector [INPUT_SIZE],
  output logic                start,
  input  logic                dnn_done,
  input  logic [3:0]          dnn_digit,
  output logic                result_valid,
  output logic [3:0]          result_digit,
  output logic                frame_err
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INPUT_SIZE - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              wr_en;
  logic              err_next;
  logic              capture;
  logic              beat;
  logic signed [15:0] sample;

`ifdef DNN_LOADER_NORMALIZE_EN
  assign sample = {1'b0, s_data, 7'b0};
`else
  assign sample = {8'b0, s_data};
`endif

  assign s_ready = (state == LOAD);
  assign beat    = s_valid && s_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wr_en      = 1'b0;
    err_next   = 1'b0;
    capture    = 1'b0;
    case (state)
      LOAD: begin
        if (beat) begin
          wr_en = 1'b1;
          if (cnt == LAST_IDX) begin
            // Buffer full: either a clean frame end or a missing s_last.
            // The counter never wraps; it always restarts from zero.
            cnt_next = '0;
            if (s_last) state_next = RUN;
            else        err_next   = 1'b1;
          end else if (s_last) begin
            // Short frame: stale entries are overwritten by the next frame.
            cnt_next = '0;
            err_next = 1'b1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (dnn_done) begin
          capture    = 1'b1;
          state_next = REPORT;
        end
      end
      REPORT: begin
        state_next = LOAD;
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register instead of lagging it by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      cnt          <= '0;
      start        <= 1'b0;
      result_valid <= 1'b0;
      result_digit <= 4'd0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      start        <= (state_next == RUN);
      result_valid <= (state_next == REPORT);
      frame_err    <= err_next;
      if (capture) result_digit <= dnn_digit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < INPUT_SIZE; i++) input_vector[i] <= '0;
    end else if (wr_en) begin
      input_vector[cnt] <= sample;
    end
  end

endmodule
